// File: rtl/pong_game_ctrl.sv
// Frame-rate game sequencer for the ping-pong display: serve/play/miss state machine,
// ball and paddle kinematics, score and lives, all updated once per frame_tick.
module pong_game_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int WALL_X       = 32,
    parameter int PADDLE_X     = 600,
    parameter int PADDLE_W     = 4,
    parameter int PADDLE_H     = 72,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_STEP    = 2,
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       up_en,
    input  logic       down_en,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_y,
    output logic [6:0] score,
    output logic [2:0] lives,
    output logic [2:0] state,
    output logic       hit,
    output logic       miss
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic signed [10:0] X_MAX_S    = 11'(H_RES - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX_S    = 11'(V_RES - BALL_SIZE);
    localparam logic signed [10:0] PAD_MAX_S  = 11'(V_RES - PADDLE_H);
    localparam logic signed [10:0] BS_S       = 11'(BALL_SIZE);
    localparam logic signed [10:0] BSTEP_S    = 11'(BALL_STEP);
    localparam logic signed [10:0] PSTEP_S    = 11'(PADDLE_STEP);
    localparam logic signed [10:0] PAD_X_S    = 11'(PADDLE_X);
    localparam logic signed [10:0] PAD_X_HI_S = 11'(PADDLE_X + PADDLE_W + BALL_STEP);
    localparam logic signed [10:0] PAD_H_S    = 11'(PADDLE_H);
    localparam logic signed [10:0] WALL_HI_S  = 11'(WALL_X + BALL_STEP);
    localparam logic signed [10:0] BOT_S      = 11'(V_RES - BALL_SIZE - BALL_STEP);

    localparam logic [9:0]       BALL_X0    = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]       BALL_Y0    = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0]       PADDLE_Y0  = 10'((V_RES - PADDLE_H) / 2);
    localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [6:0]       SCORE_MAX  = 7'd99;

    state_t           state_r;
    logic [9:0]       ball_x_r;
    logic [9:0]       ball_y_r;
    logic [9:0]       paddle_y_r;
    logic [6:0]       score_r;
    logic [2:0]       lives_r;
    logic             dx_pos_r;
    logic             dy_pos_r;
    logic             hit_r;
    logic             miss_r;
    logic             any_prev_r;
    logic [CNT_W-1:0] serve_cnt_r;

    logic signed [10:0] bx_s;
    logic signed [10:0] by_s;
    logic signed [10:0] pad_s;
    logic [9:0]         pad_next_s;
    logic [9:0]         bx_next_s;
    logic [9:0]         by_next_s;
    logic               dx_next_s;
    logic               dy_next_s;
    logic               edge_miss_s;
    logic               paddle_hit_s;
    logic               press_s;

    // Saturate a signed intermediate into [0, hi] so registered coordinates never wrap.
    function automatic logic [9:0] clamp10(input logic signed [10:0] v, input logic signed [10:0] hi);
        logic [9:0] r;
        if (v < 11'sd0) begin
            r = 10'd0;
        end else if (v > hi) begin
            r = hi[9:0];
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

    // Next-frame kinematics, collision tests and press detection from the current registers.
    always_comb begin
        bx_s  = signed'({1'b0, ball_x_r});
        by_s  = signed'({1'b0, ball_y_r});
        pad_s = signed'({1'b0, paddle_y_r});

        if (up_en && !down_en) begin
            pad_next_s = clamp10(pad_s - PSTEP_S, PAD_MAX_S);
        end else if (down_en && !up_en) begin
            pad_next_s = clamp10(pad_s + PSTEP_S, PAD_MAX_S);
        end else begin
            pad_next_s = paddle_y_r;
        end

        edge_miss_s  = (bx_s >= X_MAX_S);
        paddle_hit_s = dx_pos_r
                    && (bx_s + BS_S >= PAD_X_S)
                    && (bx_s + BS_S <= PAD_X_HI_S)
                    && (by_s + BS_S > pad_s)
                    && (by_s < pad_s + PAD_H_S);

        if (paddle_hit_s) begin
            dx_next_s = 1'b0;
        end else if (!dx_pos_r && (bx_s <= WALL_HI_S)) begin
            dx_next_s = 1'b1;
        end else begin
            dx_next_s = dx_pos_r;
        end

        if (!dy_pos_r && (by_s <= BSTEP_S)) begin
            dy_next_s = 1'b1;
        end else if (dy_pos_r && (by_s >= BOT_S)) begin
            dy_next_s = 1'b0;
        end else begin
            dy_next_s = dy_pos_r;
        end

        bx_next_s = clamp10(dx_next_s ? (bx_s + BSTEP_S) : (bx_s - BSTEP_S), X_MAX_S);
        by_next_s = clamp10(dy_next_s ? (by_s + BSTEP_S) : (by_s - BSTEP_S), Y_MAX_S);

        press_s = (up_en || down_en) && !any_prev_r;
    end

    // Game state machine; everything advances only on frame_tick, hit/miss are single-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ball_x_r    <= BALL_X0;
            ball_y_r    <= BALL_Y0;
            paddle_y_r  <= PADDLE_Y0;
            score_r     <= 7'd0;
            lives_r     <= LIVES_INIT;
            dx_pos_r    <= 1'b0;
            dy_pos_r    <= 1'b1;
            hit_r       <= 1'b0;
            miss_r      <= 1'b0;
            any_prev_r  <= 1'b0;
            serve_cnt_r <= '0;
        end else begin
            hit_r  <= 1'b0;
            miss_r <= 1'b0;
            if (frame_tick) begin
                any_prev_r <= up_en || down_en;
                case (state_r)
                    ST_IDLE: begin
                        ball_x_r   <= BALL_X0;
                        ball_y_r   <= BALL_Y0;
                        paddle_y_r <= PADDLE_Y0;
                        dx_pos_r   <= 1'b0;
                        dy_pos_r   <= 1'b1;
                        if (press_s) begin
                            state_r     <= ST_SERVE;
                            score_r     <= 7'd0;
                            lives_r     <= LIVES_INIT;
                            serve_cnt_r <= SERVE_LOAD;
                        end
                    end
                    ST_SERVE: begin
                        paddle_y_r <= pad_next_s;
                        ball_x_r   <= BALL_X0;
                        ball_y_r   <= BALL_Y0;
                        dx_pos_r   <= 1'b0;
                        dy_pos_r   <= 1'b1;
                        if (serve_cnt_r <= CNT_W'(1)) begin
                            state_r     <= ST_PLAY;
                            serve_cnt_r <= '0;
                        end else begin
                            serve_cnt_r <= serve_cnt_r - CNT_W'(1);
                        end
                    end
                    ST_PLAY: begin
                        paddle_y_r <= pad_next_s;
                        if (edge_miss_s) begin
                            state_r <= ST_MISS;
                            miss_r  <= 1'b1;
                        end else begin
                            ball_x_r <= bx_next_s;
                            ball_y_r <= by_next_s;
                            dx_pos_r <= dx_next_s;
                            dy_pos_r <= dy_next_s;
                            if (paddle_hit_s) begin
                                hit_r <= 1'b1;
                                if (score_r < SCORE_MAX) begin
                                    score_r <= score_r + 7'd1;
                                end
                            end
                        end
                    end
                    ST_MISS: begin
                        if (lives_r <= 3'd1) begin
                            lives_r <= 3'd0;
                            state_r <= ST_OVER;
                        end else begin
                            lives_r     <= lives_r - 3'd1;
                            state_r     <= ST_SERVE;
                            ball_x_r    <= BALL_X0;
                            ball_y_r    <= BALL_Y0;
                            dx_pos_r    <= 1'b0;
                            dy_pos_r    <= 1'b1;
                            serve_cnt_r <= SERVE_LOAD;
                        end
                    end
                    ST_OVER: begin
                        if (press_s) begin
                            state_r    <= ST_IDLE;
                            ball_x_r   <= BALL_X0;
                            ball_y_r   <= BALL_Y0;
                            paddle_y_r <= PADDLE_Y0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ball_x   = ball_x_r;
    assign ball_y   = ball_y_r;
    assign paddle_y = paddle_y_r;
    assign score    = score_r;
    assign lives    = lives_r;
    assign state    = state_r;
    assign hit      = hit_r;
    assign miss     = miss_r;

endmodule
